// File: rtl/aes256_enc_core.sv
// aes256_enc_core: iterative AES-256 encryption datapath, one round per clock.
// Takes the 15 pre-expanded round keys and encrypts one 128-bit block per
// valid/ready transaction. Byte 0 of every 128-bit word sits in bits [127:120]
// and the state is column-major (byte index = row + 4*column).
// Optional feature macro: AES_ENC_ABORT_EN adds an 'abort' input that cancels
// the block in flight (ROUND or DONE) and returns to IDLE without output.

module aes256_enc_core #(
  parameter int NR = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1919:0] round_keys,
  input  logic          key_valid,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef AES_ENC_ABORT_EN
  input  logic          abort,
`endif
  output logic [127:0]  out_data
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic         keys_ok;
  logic         abort_hit;

  logic [127:0] cur_rk;
  logic [127:0] sub_out;
  logic [127:0] sr_out;
  logic [127:0] mid_round;
  logic [127:0] last_round;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = SBOX[{~w[8*i +: 8], 3'b111} -: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c+rr)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return r;
  endfunction

`ifdef AES_ENC_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // SubBytes is four 32-bit SubWord lookups side by side.
  for (genvar g = 0; g < 4; g++) begin : g_subword
    assign sub_out[32*g +: 32] = sub_word(st[32*g +: 32]);
  end

  assign cur_rk     = round_keys[{rnd, 7'd0} +: 128];
  assign sr_out     = shift_rows(sub_out);
  assign mid_round  = mix_columns(sr_out) ^ cur_rk;
  assign last_round = sr_out ^ cur_rk;
  assign out_data   = st;

  // Control FSM and round state; in_ready/out_valid are registered alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      st        <= '0;
      rnd       <= '0;
      keys_ok   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (key_valid) keys_ok <= 1'b1;
      if (abort_hit && fsm != IDLE) begin
        fsm       <= IDLE;
        st        <= '0;
        rnd       <= '0;
        out_valid <= 1'b0;
        in_ready  <= keys_ok;
      end else begin
        case (fsm)
          IDLE: begin
            in_ready <= keys_ok | key_valid;
            if (in_valid && in_ready) begin
              st       <= in_data ^ round_keys[127:0];
              rnd      <= 4'd1;
              fsm      <= ROUND;
              in_ready <= 1'b0;
            end
          end
          ROUND: begin
            if (rnd == LAST_RND) begin
              st        <= last_round;
              fsm       <= DONE;
              out_valid <= 1'b1;
            end else begin
              st  <= mid_round;
              rnd <= rnd + 4'd1;
            end
          end
          DONE: begin
            if (out_ready) begin
              fsm       <= IDLE;
              out_valid <= 1'b0;
              in_ready  <= keys_ok;
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes256_enc_core.sv
// tb_aes256_enc_core: self-checking bench for aes256_enc_core (NR=14).
// Reference model builds the S-box from GF(2^8) inversion plus the affine map,
// expands AES-256 keys itself and encrypts on a 4x4 byte matrix.
// With AES_ENC_ABORT_EN defined the abort path is exercised as well.

module tb_aes256_enc_core;

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk;
  logic          rst_n;
  logic [1919:0] round_keys;
  logic          key_valid;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
`ifdef AES_ENC_ABORT_EN
  logic          abort;
`endif

  int checks;
  int errors;
  logic [7:0] sb [256];

  aes256_enc_core #(.NR(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .round_keys (round_keys),
    .key_valid  (key_valid),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef AES_ENC_ABORT_EN
    .abort      (abort),
`endif
    .out_data   (out_data)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some wait is never satisfied.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = gf_inv(8'(i));
      sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] model_sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand_key(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] rks;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = model_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = model_sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [1919:0] rks);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] rk;
    logic [127:0] ct;
    for (int k = 0; k < 16; k++) s[k%4][k/4] = pt[127-8*k -: 8];
    for (int rd = 0; rd <= 14; rd++) begin
      if (rd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            t[r][c] = sb[s[r][(c+r)%4]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            if (rd < 14)
              s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
            else
              s[r][c] = t[r][c];
      end
      rk = rks[128*rd +: 128];
      for (int k = 0; k < 16; k++) s[k%4][k/4] = s[k%4][k/4] ^ rk[127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k%4][k/4];
    return ct;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_key();
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  // One full transaction: accept, wait for result, optional backpressure, drain.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] exp_ct, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    checkOutput("accept_ready", 128'(in_ready), 128'd1);
    if (!in_ready) return;
    in_valid  = 1'b1;
    in_data   = pt;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    checkOutput("busy_in_ready", 128'(in_ready), 128'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    checkOutput("latency", 128'(n), 128'd14);
    checkOutput("ciphertext", out_data, exp_ct);
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput("hold_valid", 128'(out_valid), 128'd1);
      checkOutput("hold_data", out_data, exp_ct);
    end
    out_ready = 1'b1;
    step();
    checkOutput("valid_drop", 128'(out_valid), 128'd0);
    checkOutput("ready_back", 128'(in_ready), 128'd1);
  endtask

  logic [1919:0] rk_c3;
  logic [1919:0] rks;
  logic [255:0]  key;
  logic [127:0]  pt;
  int            cyc;
  int            n;
  logic          got_ct1;
  logic          accepted;

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
`ifdef AES_ENC_ABORT_EN
    abort      = 1'b0;
`endif
    build_sbox();
    rk_c3      = expand_key(KEY_C3);
    round_keys = rk_c3;

    repeat (3) step();
    checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_out_data", out_data, 128'd0);
    rst_n = 1'b1;

    // Plaintext offered before any key: must be ignored.
    in_valid = 1'b1;
    in_data  = PT_C3;
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("nokey_in_ready", 128'(in_ready), 128'd0);
      checkOutput("nokey_out_valid", 128'(out_valid), 128'd0);
    end
    in_valid = 1'b0;
    pulse_key();
    checkOutput("key_in_ready", 128'(in_ready), 128'd1);

    $display("[TB] FIPS-197 C.3 vector");
    applyStimulus(PT_C3, CT_C3, 0);
    $display("[TB] backpressure");
    applyStimulus(PT_C3, CT_C3, 7);

    $display("[TB] back-to-back");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = PT_C3;
    step();
    in_data  = '0;
    cyc      = 0;
    got_ct1  = 1'b0;
    accepted = 1'b0;
    while (!accepted && cyc < 60) begin
      if (out_valid) begin
        checkOutput("b2b_ct1", out_data, CT_C3);
        got_ct1 = 1'b1;
      end
      if (in_ready) accepted = 1'b1;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("b2b_ct1_seen", 128'(got_ct1), 128'd1);
    checkOutput("b2b_gap", 128'(cyc), 128'd16);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    checkOutput("b2b_latency2", 128'(n), 128'd14);
    checkOutput("b2b_ct2", out_data, model_encrypt(128'd0, rk_c3));
    step();
    checkOutput("b2b_drop", 128'(out_valid), 128'd0);

    $display("[TB] random keys and plaintexts");
    for (int t = 0; t < 8; t++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rks = expand_key(key);
      round_keys = rks;
      pulse_key();
      applyStimulus(pt, model_encrypt(pt, rks), int'($urandom_range(0, 4)));
    end
    round_keys = rk_c3;

`ifdef AES_ENC_ABORT_EN
    $display("[TB] abort mid-block");
    in_valid = 1'b1;
    in_data  = PT_C3;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_in_ready", 128'(in_ready), 128'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("abort_no_output", 128'(out_valid), 128'd0);
    end
    applyStimulus(PT_C3, CT_C3, 0);
`endif

    $display("[TB] reset mid-operation");
    in_valid = 1'b1;
    in_data  = PT_C3;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
    repeat (3) step();
    checkOutput("rst_hold_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_out_data", out_data, 128'd0);
    in_valid = 1'b1;
    rst_n    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("post_rst_in_ready", 128'(in_ready), 128'd0);
      checkOutput("post_rst_out_valid", 128'(out_valid), 128'd0);
    end
    in_valid = 1'b0;
    pulse_key();
    checkOutput("post_rst_key_ready", 128'(in_ready), 128'd1);
    applyStimulus(PT_C3, CT_C3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
